hex_scroll_ctrl: RTL and testbench

- Sequences a scrolling text message across the board's six seven-segment displays (HEX5 leftmost … HEX0 rightmost).
- Holds a small writable message store of 4-bit letter codes and a scroll position; run/step/direction controls come from switches and keys.
- Drives active-low segments through per-digit letter decoders; sits between the switch/key inputs and the HEX pins.

---
 rtl/hex_scroll_pkg.sv | 55 +++++
 rtl/hex_scroll_ctrl_if.sv | 25 ++
 rtl/letter_seg7.sv | 25 ++
 rtl/hex_scroll_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hex_scroll_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/hex_scroll_pkg.sv
// Shared letter codes, segment patterns, FSM states and the power-up message
// for the scrolling seven-segment text controller.
package hex_scroll_pkg;

  localparam logic [3:0] CODE_O     = 4'd0;
  localparam logic [3:0] CODE_L     = 4'd1;
  localparam logic [3:0] CODE_E     = 4'd2;
  localparam logic [3:0] CODE_G     = 4'd3;
  localparam logic [3:0] CODE_H     = 4'd4;
  localparam logic [3:0] CODE_I     = 4'd5;
  localparam logic [3:0] CODE_B     = 4'd6;
  localparam logic [3:0] CODE_P     = 4'd7;
  localparam logic [3:0] CODE_C     = 4'd8;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  // Active-low patterns, bit 6 = g ... bit 0 = a.
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_G     = 7'b1000010;
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_I     = 7'b1111001;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_e;

  localparam int MSG_MAX = 16;

  // Element 0 is the rightmost nibble: O,L,E,G,_,H,I,B,P,C then blanks.
  localparam logic [MSG_MAX-1:0][3:0] DEFAULT_MSG = {
    CODE_BLANK, CODE_BLANK, CODE_BLANK, CODE_BLANK, CODE_BLANK, CODE_BLANK,
    CODE_C, CODE_P, CODE_B, CODE_I, CODE_H, CODE_BLANK,
    CODE_G, CODE_E, CODE_L, CODE_O
  };

  function automatic logic [3:0] step_pos(input logic [3:0] p,
                                          input logic       d,
                                          input logic [3:0] last);
    logic [3:0] r;
    if (d == 1'b0) begin
      r = (p == last) ? 4'd0 : p + 4'd1;
    end else begin
      r = (p == 4'd0) ? last : p - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_scroll_ctrl_if.sv
// Control and display bundle between the switch/key front end and the
// scrolling controller.
interface hex_scroll_ctrl_if #(
  parameter int NUM_DIGITS = 6
);
  logic                    run;
  logic                    step;
  logic                    dir;
  logic                    load_en;
  logic [3:0]              load_addr;
  logic [3:0]              load_code;
  logic [7*NUM_DIGITS-1:0] HEX_SEG;
  logic [3:0]              pos;
  logic                    tick_out;

  modport master (
    output run, step, dir, load_en, load_addr, load_code,
    input  HEX_SEG, pos, tick_out
  );

  modport slave (
    input  run, step, dir, load_en, load_addr, load_code,
    output HEX_SEG, pos, tick_out
  );
endinterface

// File: rtl/letter_seg7.sv
// Combinational letter-code to active-low seven-segment decoder; codes with
// no glyph show blank.
module letter_seg7
  import hex_scroll_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (code_i)
      CODE_O:  seg_o = SEG_O;
      CODE_L:  seg_o = SEG_L;
      CODE_E:  seg_o = SEG_E;
      CODE_G:  seg_o = SEG_G;
      CODE_H:  seg_o = SEG_H;
      CODE_I:  seg_o = SEG_I;
      CODE_B:  seg_o = SEG_B;
      CODE_P:  seg_o = SEG_P;
      CODE_C:  seg_o = SEG_C;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Scrolling text controller for the six-digit seven-segment bank.
// Optional HOLD-mode blinking is enabled by defining HEX_SCROLL_BLINK_EN.
module hex_scroll_ctrl
  import hex_scroll_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_LEN    = 10,
  parameter int TICK_DIV   = 25000000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  hex_scroll_ctrl_if.slave  bus
);

  localparam int             HEX_W = 7 * NUM_DIGITS;
  localparam int             PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  TC    = PW'(TICK_DIV - 1);
  localparam logic [3:0]     LAST  = 4'(MSG_LEN - 1);
`ifdef HEX_SCROLL_BLINK_EN
  localparam logic           BLINK_ON = 1'b1;
`else
  localparam logic           BLINK_ON = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [3:0]       pos_q, pos_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_q, tick_d;
  logic             blink_q, blink_d;
  logic             terminal_s;
  logic [3:0]       msg_q [MSG_MAX];
  logic [HEX_W-1:0] seg_s;
  logic [HEX_W-1:0] hex_q, hex_d;

  assign terminal_s = (presc_q == TC);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    blink_d = blink_q;
    case (state_q)
      HOLD: begin
        if (bus.load_en) begin
          state_d = LOAD;
          presc_d = '0;
          blink_d = 1'b0;
        end else begin
          if (bus.step) begin
            pos_d = step_pos(pos_q, bus.dir, LAST);
          end else begin
            pos_d = pos_q;
          end
          if (bus.run) begin
            state_d = RUN;
            presc_d = '0;
            blink_d = 1'b0;
          end else if (BLINK_ON && terminal_s) begin
            presc_d = '0;
            tick_d  = 1'b1;
            blink_d = ~blink_q;
          end else if (BLINK_ON) begin
            presc_d = presc_q + PW'(1);
          end else begin
            presc_d = '0;
          end
        end
      end
      RUN: begin
        if (bus.load_en) begin
          state_d = LOAD;
          presc_d = '0;
          blink_d = 1'b0;
        end else if (!bus.run) begin
          state_d = HOLD;
          presc_d = '0;
        end else if (terminal_s) begin
          presc_d = '0;
          tick_d  = 1'b1;
          pos_d   = step_pos(pos_q, bus.dir, LAST);
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      LOAD: begin
        // Leaving LOAD always lands in HOLD at the message start, even with run high.
        if (!bus.load_en) begin
          state_d = HOLD;
          pos_d   = 4'd0;
        end else begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = HOLD;
        pos_d   = 4'd0;
        presc_d = '0;
        blink_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= HOLD;
      pos_q   <= 4'd0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      blink_q <= blink_d;
    end
  end

  // Message store; out-of-range addresses are dropped and spare entries stay blank.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MSG_MAX; i++) begin
        msg_q[i] <= DEFAULT_MSG[i];
      end
    end else if (bus.load_en && ({28'd0, bus.load_addr} < 32'(MSG_LEN))) begin
      msg_q[bus.load_addr] <= bus.load_code;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    logic [3:0] sel_s;
    assign sel_s = 4'((32'(pos_q) + 32'(NUM_DIGITS - 1 - g)) % 32'(MSG_LEN));
    letter_seg7 u_dec (
      .code_i (msg_q[sel_s]),
      .seg_o  (seg_s[7*g +: 7])
    );
  end

  always_comb begin
    if (BLINK_ON && blink_q) begin
      hex_d = {HEX_W{1'b1}};
    end else begin
      hex_d = seg_s;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      hex_q <= {HEX_W{1'b1}};
    end else begin
      hex_q <= hex_d;
    end
  end

  assign bus.HEX_SEG  = hex_q;
  assign bus.pos      = pos_q;
  assign bus.tick_out = tick_q;

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Directed bench for hex_scroll_ctrl with a 4-cycle prescaler (default build).
module tb_hex_scroll_ctrl;

  localparam logic [6:0] S_O  = 7'b1000000;
  localparam logic [6:0] S_L  = 7'b1000111;
  localparam logic [6:0] S_E  = 7'b0000110;
  localparam logic [6:0] S_G  = 7'b1000010;
  localparam logic [6:0] S_H  = 7'b0001001;
  localparam logic [6:0] S_I  = 7'b1111001;
  localparam logic [6:0] S_B  = 7'b0000011;
  localparam logic [6:0] S_C  = 7'b1000110;
  localparam logic [6:0] S_BL = 7'b1111111;

  localparam logic [41:0] ALL1 = {42{1'b1}};
  localparam logic [41:0] V0   = {S_O, S_L, S_E, S_G, S_BL, S_H};
  localparam logic [41:0] V9   = {S_C, S_O, S_L, S_E, S_G, S_BL};
  localparam logic [41:0] V0H  = {S_O, S_L, S_E, S_H, S_BL, S_H};
  localparam logic [41:0] V2H  = {S_E, S_H, S_BL, S_H, S_I, S_B};

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hex_scroll_ctrl_if #(.NUM_DIGITS(6)) bus ();

  hex_scroll_ctrl #(
    .NUM_DIGITS (6),
    .MSG_LEN    (10),
    .TICK_DIV   (4)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [41:0] obs, input logic [41:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.run       = 1'b0;
    bus.step      = 1'b0;
    bus.dir       = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_addr = 4'd0;
    bus.load_code = 4'd0;

    repeat (3) @(negedge clk);
    chk("reset_pos", 42'(bus.pos), 42'd0);
    chk("reset_hex", bus.HEX_SEG, ALL1);
    chk("reset_tick", 42'(bus.tick_out), 42'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("release_hex", bus.HEX_SEG, V0);

    // Auto-scroll left through a full wrap.
    bus.run = 1'b1;
    bus.dir = 1'b0;
    repeat (4) @(negedge clk);
    chk("run_first_gap_tick", 42'(bus.tick_out), 42'd0);
    chk("run_first_gap_pos", 42'(bus.pos), 42'd0);
    @(negedge clk);
    chk("run_first_tick", 42'(bus.tick_out), 42'd1);
    chk("run_first_pos", 42'(bus.pos), 42'd1);
    for (int k = 2; k <= 10; k++) begin
      repeat (3) @(negedge clk);
      chk("run_gap_tick", 42'(bus.tick_out), 42'd0);
      @(negedge clk);
      chk("run_tick", 42'(bus.tick_out), 42'd1);
      chk("run_pos", 42'(bus.pos), 42'(k % 10));
    end
    @(negedge clk);
    chk("wrap_hex", bus.HEX_SEG, V0);

    // Asynchronous reset mid-scroll.
    for (int i = 0; i < 64 && bus.pos !== 4'd7; i++) @(negedge clk);
    chk("pos7_reached", 42'(bus.pos), 42'd7);
    #2 rst = 1'b1;
    bus.run = 1'b0;
    #1;
    chk("async_rst_pos", 42'(bus.pos), 42'd0);
    chk("async_rst_hex", bus.HEX_SEG, ALL1);
    chk("async_rst_tick", 42'(bus.tick_out), 42'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rerelease_hex", bus.HEX_SEG, V0);
    chk("rerelease_pos", 42'(bus.pos), 42'd0);

    // Single step right from 0 wraps to the last index.
    bus.dir  = 1'b1;
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    chk("step_right_pos", 42'(bus.pos), 42'd9);
    @(negedge clk);
    chk("step_right_hex", bus.HEX_SEG, V9);

    // Step is ignored in RUN.
    bus.run = 1'b1;
    @(negedge clk);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    bus.run  = 1'b0;
    chk("run_step_ignored", 42'(bus.pos), 42'd9);
    @(negedge clk);
    chk("back_hold_pos", 42'(bus.pos), 42'd9);

    // Load beats run; release returns to HOLD at pos 0 even with run high.
    bus.dir       = 1'b0;
    bus.run       = 1'b1;
    bus.load_en   = 1'b1;
    bus.load_addr = 4'd3;
    bus.load_code = 4'd4;
    @(negedge clk);
    chk("load_pos_frozen", 42'(bus.pos), 42'd9);
    bus.load_en = 1'b0;
    @(negedge clk);
    chk("load_exit_pos", 42'(bus.pos), 42'd0);
    @(negedge clk);
    chk("load_hex", bus.HEX_SEG, V0H);
    repeat (3) @(negedge clk);
    chk("post_load_gap_tick", 42'(bus.tick_out), 42'd0);
    chk("post_load_gap_pos", 42'(bus.pos), 42'd0);
    @(negedge clk);
    chk("post_load_tick", 42'(bus.tick_out), 42'd1);
    chk("post_load_pos", 42'(bus.pos), 42'd1);

    // Out-of-range write is dropped.
    bus.run       = 1'b0;
    bus.load_en   = 1'b1;
    bus.load_addr = 4'd12;
    bus.load_code = 4'd0;
    @(negedge clk);
    chk("oor_pos_frozen", 42'(bus.pos), 42'd1);
    bus.load_en = 1'b0;
    @(negedge clk);
    chk("oor_exit_pos", 42'(bus.pos), 42'd0);
    @(negedge clk);
    chk("oor_hex", bus.HEX_SEG, V0H);

    // Step and run together: step now, next advance four cycles later.
    bus.step = 1'b1;
    bus.run  = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    chk("steprun_pos", 42'(bus.pos), 42'd1);
    chk("steprun_tick", 42'(bus.tick_out), 42'd0);
    repeat (3) @(negedge clk);
    chk("steprun_gap_pos", 42'(bus.pos), 42'd1);
    chk("steprun_gap_tick", 42'(bus.tick_out), 42'd0);
    @(negedge clk);
    chk("steprun_adv_pos", 42'(bus.pos), 42'd2);
    chk("steprun_adv_tick", 42'(bus.tick_out), 42'd1);

    // HOLD display stays steady with no ticks.
    bus.run = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("hold_tick", 42'(bus.tick_out), 42'd0);
      chk("hold_hex", bus.HEX_SEG, V2H);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
